// File: rtl/wave_table_loader_pkg.sv
// Shared definitions for the double-buffered wave table loader:
// default geometry and the loader FSM state encoding.
package wave_table_loader_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/wave_table_loader_bank_ram.sv
// Dual-bank sample storage: one write port into the shadow bank and a
// registered read port from the active bank, both cleared on reset.
module wave_bank_ram #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk_s,
  input  logic          rst_n,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [2][DEPTH];

  // The reader runs every cycle regardless of the writer; the loader
  // guarantees the two ports never address the same bank.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[b][i] <= '0;
        end
      end
      rd_data <= '0;
    end else begin
      if (we) begin
        mem[wr_bank][wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/wave_table_loader.sv
// Double-buffered wave table: streams a full table into the shadow bank,
// then swaps banks in a single COMMIT cycle so readers never see a partial table.
module wave_table_loader
  import wave_table_loader_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk_s,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic [AW-1:0] add,
  output logic [DW-1:0] data,
  output logic          bank,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = 2**AW;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] wr_ptr;
  logic          wr_en;
  logic          last_word;

  assign last_word = (wr_ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort takes priority over any handshake in the same LOAD cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
        end else if (s_valid && last_word) begin
          next_state = COMMIT;
        end
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    wr_en   = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        wr_en   = s_valid && !abort;
      end
      COMMIT:  busy = 1'b1;
      default: ;
    endcase
  end

  // The bank flips at the end of COMMIT so the COMMIT-cycle read still sees the old table.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      bank   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        wr_ptr <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (state == COMMIT) begin
        bank <= ~bank;
      end
      done <= (state == COMMIT);
      err  <= start && busy;
    end
  end

  wave_bank_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_s   (clk_s),
    .rst_n   (rst_n),
    .we      (wr_en),
    .wr_bank (~bank),
    .wr_addr (wr_ptr),
    .wr_data (s_data),
    .rd_bank (bank),
    .rd_addr (add),
    .rd_data (data)
  );

endmodule

// File: tb/tb_wave_table_loader.sv
// Self-checking bench for wave_table_loader: directed scenarios plus random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_wave_table_loader;

  logic       clk_s = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic [2:0] add = '0;
  logic       s_ready;
  logic [7:0] data;
  logic       bank;
  logic       busy;
  logic       done;
  logic       err;

  int checkCount = 0;
  int passCount  = 0;
  int doneSeen   = 0;
  int errSeen    = 0;

  // Reference model: a table in progress is just a word count; swapping is a pending flag.
  logic [7:0] ref_mem [2][8];
  bit         ref_bank;
  bit         ref_loading;
  bit         ref_swap_pending;
  int         ref_count;
  logic [7:0] ref_data;
  bit         ref_done;
  bit         ref_err;

  wave_table_loader #(.DW(8), .AW(3)) dut (
    .clk_s   (clk_s),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .add     (add),
    .data    (data),
    .bank    (bank),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk_s = ~clk_s;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        ref_mem[b][i] = 8'h00;
      end
    end
    ref_bank         = 1'b0;
    ref_loading      = 1'b0;
    ref_swap_pending = 1'b0;
    ref_count        = 0;
    ref_data         = 8'h00;
    ref_done         = 1'b0;
    ref_err          = 1'b0;
  endtask

  task automatic modelStep();
    bit was_busy;
    was_busy = ref_loading || ref_swap_pending;
    ref_data = ref_mem[ref_bank][add];
    ref_err  = start && was_busy;
    ref_done = ref_swap_pending;
    if (ref_swap_pending) begin
      ref_bank         = ref_bank ^ 1'b1;
      ref_swap_pending = 1'b0;
    end else if (ref_loading) begin
      if (abort) begin
        ref_loading = 1'b0;
      end else if (s_valid) begin
        ref_mem[ref_bank ^ 1'b1][ref_count] = s_data;
        ref_count++;
        if (ref_count == 8) begin
          ref_loading      = 1'b0;
          ref_swap_pending = 1'b1;
        end
      end
    end else if (start) begin
      ref_loading = 1'b1;
      ref_count   = 0;
    end
  endtask

  task automatic compareAll(input string phase);
    checkOutput({phase, ":data"},    32'(data),    32'(ref_data));
    checkOutput({phase, ":bank"},    32'(bank),    32'(ref_bank));
    checkOutput({phase, ":s_ready"}, 32'(s_ready), 32'(ref_loading));
    checkOutput({phase, ":busy"},    32'(busy),    32'(ref_loading || ref_swap_pending));
    checkOutput({phase, ":done"},    32'(done),    32'(ref_done));
    checkOutput({phase, ":err"},     32'(err),     32'(ref_err));
  endtask

  // Drives one cycle of inputs from a falling edge and checks the result on the next one.
  task automatic applyStimulus(input string phase, input bit st, input bit ab, input bit sv,
                               input logic [7:0] sd, input logic [2:0] ad);
    start   = st;
    abort   = ab;
    s_valid = sv;
    s_data  = sd;
    add     = ad;
    @(posedge clk_s);
    modelStep();
    @(negedge clk_s);
    if (done) doneSeen++;
    if (err)  errSeen++;
    compareAll(phase);
  endtask

  initial begin
    modelReset();
    #1;
    compareAll("reset");
    repeat (2) @(negedge clk_s);
    rst_n = 1'b1;

    applyStimulus("r035", 1'b0, 1'b0, 1'b0, 8'h00, 3'd5);
    checkOutput("r035_data", 32'(data), 32'h00);
    checkOutput("r035_bank", 32'(bank), 32'h0);
    checkOutput("r035_ready", 32'(s_ready), 32'h0);

    doneSeen = 0;
    applyStimulus("r036", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("r036_ready", 32'(s_ready), 32'h1);
      applyStimulus("r036", 1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 3'd0);
    end
    checkOutput("r036_commit_busy", 32'(busy), 32'h1);
    checkOutput("r036_commit_ready", 32'(s_ready), 32'h0);
    applyStimulus("r036", 1'b0, 1'b0, 1'b0, 8'h00, 3'd3);
    checkOutput("r036_old_bank_read", 32'(data), 32'h00);
    checkOutput("r036_done", 32'(done), 32'h1);
    checkOutput("r036_bank", 32'(bank), 32'h1);
    applyStimulus("r036", 1'b0, 1'b0, 1'b0, 8'h00, 3'd3);
    checkOutput("r036_data", 32'(data), 32'h13);
    checkOutput("r036_done_count", 32'(doneSeen), 32'd1);

    doneSeen = 0;
    applyStimulus("r037", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("r037_busy", 32'(busy), 32'h1);
      applyStimulus("r037", 1'b0, 1'b0, (i % 2) == 0, 8'(8'h20 + i / 2), 3'd0);
    end
    applyStimulus("r037", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    applyStimulus("r037", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    checkOutput("r037_done_count", 32'(doneSeen), 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus("r037_read", 1'b0, 1'b0, 1'b0, 8'h00, 3'(i));
      checkOutput("r037_word", 32'(data), 32'(8'h20 + i));
    end

    doneSeen = 0;
    applyStimulus("r038", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("r038", 1'b0, 1'b0, 1'b1, 8'(8'hA0 + i), 3'd0);
    end
    applyStimulus("r038", 1'b0, 1'b1, 1'b1, 8'hFF, 3'd0);
    checkOutput("r038_busy", 32'(busy), 32'h0);
    applyStimulus("r038", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    checkOutput("r038_bank", 32'(bank), 32'h0);
    checkOutput("r038_data", 32'(data), 32'h20);
    checkOutput("r038_done_count", 32'(doneSeen), 32'd0);

    errSeen = 0;
    applyStimulus("r039", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("r039", 1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 3'd0);
    end
    applyStimulus("r039", 1'b1, 1'b0, 1'b1, 8'h33, 3'd0);
    checkOutput("r039_err", 32'(err), 32'h1);
    for (int i = 4; i < 8; i++) begin
      applyStimulus("r039", 1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 3'd0);
    end
    applyStimulus("r039", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    applyStimulus("r039_b2b", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    checkOutput("r039_err_count", 32'(errSeen), 32'd1);
    checkOutput("r039_bank", 32'(bank), 32'h1);
    checkOutput("r039_b2b_load", 32'(s_ready), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus("r039_read", 1'b0, 1'b0, 1'b0, 8'h00, 3'(i));
      checkOutput("r039_word", 32'(data), 32'(8'h30 + i));
    end
    applyStimulus("r039", 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);

    for (int n = 0; n < 600; n++) begin
      applyStimulus("rand",
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 2) != 0,
                    8'($urandom),
                    3'($urandom));
    end

    applyStimulus("r040", 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    applyStimulus("r040", 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    applyStimulus("r040", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus("r040", 1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 3'(i));
    end
    checkOutput("r040_pre_busy", 32'(busy), 32'h1);
    start   = 1'b0;
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll("r040_async");
    repeat (2) @(posedge clk_s);
    @(negedge clk_s);
    rst_n    = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus("r040_read", 1'b0, 1'b0, 1'b0, 8'h00, 3'(i));
      checkOutput("r040_word", 32'(data), 32'h00);
    end
    checkOutput("r040_bank", 32'(bank), 32'h0);
    checkOutput("r040_done_count", 32'(doneSeen), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
